// File: rtl/nco_voice.sv
// Single-voice numerically controlled oscillator: a 24-bit phase accumulator stepped
// once per sample period, shaped into sawtooth/square/triangle/silence samples.
module nco_voice #(
    parameter int unsigned CLK_DIV = 2500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] fcw,
    input  logic        fcw_valid,
    output logic        fcw_ready,
    input  logic [1:0]  wave_sel,
    input  logic        sample_ready,
    output logic [20:0] wave_out,
    output logic        out_valid,
    output logic [7:0]  drop_count
);

    localparam int unsigned CW = 16;
    localparam logic [CW-1:0] LAST_COUNT = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_pend;
    logic [23:0]   r_pendFcw;
    logic [23:0]   r_activeFcw;
    logic [23:0]   r_phase;
    logic          r_load;
    logic [20:0]   r_wave;
    logic          r_valid;
    logic [7:0]    r_drops;

    logic          w_tick;
    logic          w_accept;
    logic [23:0]   w_inc;
    logic [20:0]   w_tri;
    logic [20:0]   w_sample;

    assign w_tick   = (r_cnt == LAST_COUNT);
    assign w_accept = fcw_valid && !r_pend;
    assign w_inc    = r_pend ? r_pendFcw : r_activeFcw;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // A word accepted on a tick edge is only parked; that tick still steps with the old increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend      <= 1'b0;
            r_pendFcw   <= '0;
            r_activeFcw <= '0;
            r_phase     <= '0;
            r_load      <= 1'b0;
        end else begin
            r_load <= w_tick;
            if (w_tick) begin
                r_phase <= r_phase + w_inc;
                if (r_pend) begin
                    r_activeFcw <= r_pendFcw;
                end
            end
            if (w_accept) begin
                r_pendFcw <= fcw;
                r_pend    <= 1'b1;
            end else if (w_tick) begin
                r_pend <= 1'b0;
            end
        end
    end

    always_comb begin
        w_tri    = r_phase[23] ? ~r_phase[22:2] : r_phase[22:2];
        w_sample = '0;
        case (wave_sel)
            2'd0: w_sample = {~r_phase[23], r_phase[22:3]};
            2'd1: w_sample = r_phase[23] ? 21'h100000 : 21'h0FFFFF;
            2'd2: w_sample = {~w_tri[20], w_tri[19:0]};
            default: w_sample = '0;
        endcase
    end

    // A fresh sample replacing one nobody took is a drop; replacing one being taken is not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wave  <= '0;
            r_valid <= 1'b0;
            r_drops <= '0;
        end else if (r_load) begin
            r_wave  <= w_sample;
            r_valid <= 1'b1;
            if (r_valid && !sample_ready && (r_drops != 8'hFF)) begin
                r_drops <= r_drops + 1'b1;
            end
        end else if (r_valid && sample_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign fcw_ready  = !r_pend;
    assign wave_out   = r_wave;
    assign out_valid  = r_valid;
    assign drop_count = r_drops;

endmodule
